meteor_field: RTL and testbench

METEOR_FIELD -- requirements
Module: meteor_field

---
 rtl/meteor_pkg.sv | 37 +++
 rtl/meteor_lfsr.sv | 24 ++
 rtl/meteor_field.sv | 144 ++++++++++++++
 tb/tb_meteor_field.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meteor_pkg.sv
// Shared constants, state encoding and overlap helper
// for the meteor playfield.
package meteor_pkg;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int METEOR_SZ    = 8;
  localparam int N_METEORS    = 4;
  localparam int SPAWN_PERIOD = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  localparam logic [8:0] Y_LIMIT =
    9'(SCREEN_H);
  localparam logic [7:0] X_SPAN =
    8'(SCREEN_W - METEOR_SZ);
  localparam logic [3:0] TIMER_LAST =
    4'(SPAWN_PERIOD - 1);
  localparam logic [8:0] SZ9 =
    9'(METEOR_SZ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_t;

  function automatic logic near8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, b} - {1'b0, a};
    return d < SZ9;
  endfunction

endpackage

// File: rtl/meteor_lfsr.sv
// Free-running 16-bit Fibonacci LFSR,
// taps 16,14,13,11; only hard reset reseeds it.
module meteor_lfsr
  import meteor_pkg::*;
(
  input  logic        i_clk,
  input  logic        reset,
  output logic [15:0] out
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        fb;

  assign fb = lfsr_q[15] ^ lfsr_q[13]
            ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d = {lfsr_q[14:0], fb};
  assign out    = lfsr_q;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/meteor_field.sv
// Meteor playfield: per-frame fall, timed spawn,
// dodge counting and player collision FSM.
module meteor_field
  import meteor_pkg::*;
(
  input  logic        i_clk,
  input  logic        reset,
  input  logic        restart,
  input  logic        enable,
  input  logic        frame,
  input  logic [7:0]  speed,
  input  logic [7:0]  player_x,
  input  logic [6:0]  player_y,
  output logic [31:0] meteor_x,
  output logic [27:0] meteor_y,
  output logic [3:0]  meteor_active,
  output logic [15:0] dodged,
  output logic        hit,
  output logic        running
);

  state_t state_q, state_d;

  logic [N_METEORS-1:0][7:0] x_q, x_d;
  logic [N_METEORS-1:0][6:0] y_q, y_d;
  logic [N_METEORS-1:0]      act_q, act_d;
  logic [15:0]               dod_q, dod_d;
  logic [3:0]                tim_q, tim_d;

  logic [15:0] lfsr;
  logic [7:0]  spawn_x;
  logic [8:0]  y_nxt;
  logic [2:0]  n_exit;
  logic [16:0] dod_sum;
  logic        spawned;
  logic        collide;

  meteor_lfsr u_lfsr (
    .i_clk (i_clk),
    .reset (reset),
    .out   (lfsr)
  );

  assign spawn_x = (lfsr[7:0] >= X_SPAN)
                 ? lfsr[7:0] - X_SPAN
                 : lfsr[7:0];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    act_d   = act_q;
    dod_d   = dod_q;
    tim_d   = tim_q;
    y_nxt   = '0;
    n_exit  = '0;
    dod_sum = '0;
    spawned = 1'b0;
    collide = 1'b0;
    if (restart) begin
      state_d = IDLE;
      x_d     = '0;
      y_d     = '0;
      act_d   = '0;
      dod_d   = '0;
      tim_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable) state_d = RUN;
        end
        RUN: begin
          if (frame) begin
            tim_d = tim_q + 4'd1;
            for (int i = 0; i < N_METEORS; i++) begin
              if (act_q[i]) begin
                y_nxt = {2'b00, y_q[i]}
                      + {1'b0, speed};
                if (y_nxt >= Y_LIMIT) begin
                  act_d[i] = 1'b0;
                  n_exit   = n_exit + 3'd1;
                end else begin
                  y_d[i] = y_nxt[6:0];
                end
              end
            end
            dod_sum = {1'b0, dod_q} + 17'(n_exit);
            dod_d   = dod_sum[16] ? 16'hFFFF
                                  : dod_sum[15:0];
            // pick from the pre-move mask so freed slots wait a frame
            if (tim_q == TIMER_LAST) begin
              for (int i = 0; i < N_METEORS; i++) begin
                if (!spawned && !act_q[i]) begin
                  spawned  = 1'b1;
                  act_d[i] = 1'b1;
                  x_d[i]   = spawn_x;
                  y_d[i]   = '0;
                end
              end
            end
            for (int i = 0; i < N_METEORS; i++) begin
              if (act_d[i]
                  && near8(x_d[i], player_x)
                  && near8({1'b0, y_d[i]},
                           {1'b0, player_y}))
                collide = 1'b1;
            end
            if (collide) state_d = HIT;
          end
        end
        HIT: begin
          state_d = HIT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      act_q   <= '0;
      dod_q   <= '0;
      tim_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      act_q   <= act_d;
      dod_q   <= dod_d;
      tim_q   <= tim_d;
    end
  end

  assign meteor_x      = x_q;
  assign meteor_y      = y_q;
  assign meteor_active = act_q;
  assign dodged        = dod_q;
  assign hit           = (state_q == HIT);
  assign running       = (state_q == RUN);

endmodule

// File: tb/tb_meteor_field.sv
// Directed + random bench for meteor_field against
// a behavioural model of the playfield rules.
module tb_meteor_field;

  logic        i_clk = 1'b0;
  logic        reset;
  logic        restart;
  logic        enable;
  logic        frame;
  logic [7:0]  speed;
  logic [7:0]  player_x;
  logic [6:0]  player_y;
  logic [31:0] meteor_x;
  logic [27:0] meteor_y;
  logic [3:0]  meteor_active;
  logic [15:0] dodged;
  logic        hit;
  logic        running;

  int checks = 0;
  int errors = 0;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HIT  = 2;

  int mst, mdod, mtim, mL;
  int mx [4];
  int my [4];
  bit ma [4];

  logic [27:0] ysnap;
  logic [31:0] xsnap;

  meteor_field dut (
    .i_clk         (i_clk),
    .reset         (reset),
    .restart       (restart),
    .enable        (enable),
    .frame         (frame),
    .speed         (speed),
    .player_x      (player_x),
    .player_y      (player_y),
    .meteor_x      (meteor_x),
    .meteor_y      (meteor_y),
    .meteor_active (meteor_active),
    .dodged        (dodged),
    .hit           (hit),
    .running       (running)
  );

  always #5 i_clk = ~i_clk;

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 'hFFFF;
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_clear();
    mst  = M_IDLE;
    mdod = 0;
    mtim = 0;
    for (int i = 0; i < 4; i++) begin
      mx[i] = 0; my[i] = 0; ma[i] = 0;
    end
  endtask

  task automatic model_cycle(input bit f, input bit rs,
                             input bit en, input int spd,
                             input int px, input int py);
    bit was [4];
    int yn, nd, slot, lo;
    bit hf;
    if (rs) begin
      model_clear();
    end else if (mst == M_IDLE) begin
      if (en) mst = M_RUN;
    end else if (mst == M_RUN && f) begin
      was = ma;
      nd  = 0;
      for (int i = 0; i < 4; i++) begin
        if (ma[i]) begin
          yn = my[i] + spd;
          if (yn >= 120) begin ma[i] = 0; nd++; end
          else my[i] = yn;
        end
      end
      mdod = (mdod + nd > 65535) ? 65535 : mdod + nd;
      if (mtim == 15) begin
        slot = -1;
        for (int i = 0; i < 4; i++)
          if (!was[i] && slot < 0) slot = i;
        if (slot >= 0) begin
          lo = mL % 256;
          ma[slot] = 1;
          my[slot] = 0;
          mx[slot] = (lo >= 152) ? lo - 152 : lo;
        end
      end
      mtim = (mtim + 1) % 16;
      hf = 0;
      for (int i = 0; i < 4; i++)
        if (ma[i] && absd(mx[i], px) < 8
            && absd(my[i], py) < 8) hf = 1;
      if (hf) mst = M_HIT;
    end
    mL = lfsr_next(mL);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic check_all(input string ph);
    logic [31:0] ex;
    logic [27:0] ey;
    logic [3:0]  ea;
    int t;
    for (int i = 0; i < 4; i++) begin
      t = mx[i]; ex[8*i +: 8] = t[7:0];
      t = my[i]; ey[7*i +: 7] = t[6:0];
      ea[i] = ma[i];
    end
    chk({ph, ".x"}, meteor_x, ex);
    chk({ph, ".y"}, {4'b0, meteor_y}, {4'b0, ey});
    chk({ph, ".act"}, {28'b0, meteor_active}, {28'b0, ea});
    chk({ph, ".dod"}, {16'b0, dodged}, mdod);
    chk({ph, ".hit"}, {31'b0, hit}, (mst == M_HIT) ? 1 : 0);
    chk({ph, ".run"}, {31'b0, running}, (mst == M_RUN) ? 1 : 0);
  endtask

  task automatic step(input string ph, input bit f,
                      input bit rs, input bit en,
                      input int spd, input int px,
                      input int py);
    frame    = f;
    restart  = rs;
    enable   = en;
    speed    = spd[7:0];
    player_x = px[7:0];
    player_y = py[6:0];
    model_cycle(f, rs, en, spd, px, py);
    @(posedge i_clk);
    #1;
    check_all(ph);
    frame   = 1'b0;
    restart = 1'b0;
  endtask

  task automatic frames(input string ph, input int n,
                        input int spd, input int px,
                        input int py);
    for (int k = 0; k < n; k++) begin
      step(ph, 1'b1, 1'b0, 1'b1, spd, px, py);
      repeat ($urandom_range(0, 2))
        step(ph, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
             spd, px, py);
    end
  endtask

  task automatic do_reset(input string ph);
    reset = 1'b1;
    #1;
    model_clear();
    mL = 'hACE1;
    check_all(ph);
    @(posedge i_clk);
    #1;
    reset = 1'b0;
    frame = 1'b0;
  endtask

  initial begin
    int fx, f, en, spd;
    bit rs;
    reset    = 1'b1;
    restart  = 1'b0;
    enable   = 1'b0;
    frame    = 1'b0;
    speed    = '0;
    player_x = '0;
    player_y = '0;
    do_reset("reset");

    // frames ignored while idle
    for (int k = 0; k < 4; k++)
      step("idle", 1'b1, 1'b0, 1'b0, 5, 0, 0);

    // first spawn after 16 frames
    step("start", 1'b0, 1'b0, 1'b1, 3, 0, 100);
    frames("spawn16", 15, 3, 0, 100);
    chk("pre16.act", {28'b0, meteor_active}, 0);
    frames("spawn16", 1, 3, 0, 100);
    chk("f16.act", {28'b0, meteor_active}, 1);
    chk("f16.y0", {25'b0, meteor_y[6:0]}, 0);
    chk("f16.run", {31'b0, running}, 1);

    // fall to y=117 then exit at exactly 120
    fx = (mx[0] >= 128) ? 0 : 200;
    frames("fall", 13, 9, fx, 100);
    chk("y117", {25'b0, meteor_y[6:0]}, 117);
    frames("exit", 1, 3, fx, 100);
    chk("exit.act", {28'b0, meteor_active}, 0);
    chk("exit.dod", {16'b0, dodged}, 1);

    // collision edge: dx=8 misses, dx=7 hits
    frames("respawn", 2, 0, 0, 100);
    frames("descend", 5, 10, 0, 100);
    chk("y50", {25'b0, meteor_y[6:0]}, 50);
    frames("miss8", 1, 0, mx[0] + 8, 57);
    chk("miss8.hit", {31'b0, hit}, 0);
    frames("hit7", 1, 0, mx[0] + 7, 57);
    chk("hit7.hit", {31'b0, hit}, 1);
    chk("hit7.run", {31'b0, running}, 0);
    ysnap = meteor_y;
    xsnap = meteor_x;
    for (int k = 0; k < 4; k++)
      step("frozen", 1'b1, 1'b0, 1'b1,
           $urandom_range(1, 40), 0, 0);
    chk("frozen.y", {4'b0, meteor_y}, {4'b0, ysnap});
    chk("frozen.x", meteor_x, xsnap);
    step("restart", 1'b0, 1'b1, 1'b1, 0, 0, 0);
    chk("restart.dod", {16'b0, dodged}, 0);

    // full field drops spawn, timer still wraps
    step("en2", 1'b0, 1'b0, 1'b1, 0, 0, 100);
    frames("fill", 64, 0, 0, 100);
    chk("full.act", {28'b0, meteor_active}, 'hF);
    frames("drop", 16, 0, 0, 100);
    chk("drop.act", {28'b0, meteor_active}, 'hF);
    frames("wrap", 15, 0, 0, 100);
    frames("wrapx", 1, 120, 0, 100);
    chk("allexit.act", {28'b0, meteor_active}, 0);
    chk("allexit.dod", {16'b0, dodged}, 4);

    // exit on wrap frame: freed slots wait, slot3 spawns
    frames("fill3", 48, 0, 0, 100);
    chk("fill3.act", {28'b0, meteor_active}, 'h7);
    frames("pre", 15, 0, 0, 100);
    frames("swap", 1, 120, 0, 100);
    chk("swap.act", {28'b0, meteor_active}, 'h8);
    chk("swap.dod", {16'b0, dodged}, 7);

    // random play with restarts out of HIT
    step("rnd0", 1'b0, 1'b1, 1'b0, 0, 0, 0);
    for (int k = 0; k < 500; k++) begin
      f   = $urandom_range(0, 1);
      en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      spd = ($urandom_range(0, 15) == 0)
          ? 255 : $urandom_range(0, 20);
      if (mst == M_HIT) rs = ($urandom_range(0, 7) == 0);
      else              rs = ($urandom_range(0, 199) == 0);
      step("rnd", 1'(f), rs, 1'(en), spd,
           $urandom_range(0, 255), $urandom_range(0, 127));
    end

    // reset during a frame pulse in RUN
    step("pre35", 1'b0, 1'b1, 1'b0, 0, 0, 0);
    step("pre35", 1'b0, 1'b0, 1'b1, 0, 0, 100);
    frames("pre35", 20, 2, 0, 100);
    chk("pre35.act", {28'b0, meteor_active}, 1);
    frame = 1'b1;
    speed = 8'd3;
    do_reset("midreset");
    chk("midreset.act", {28'b0, meteor_active}, 0);
    chk("midreset.dod", {16'b0, dodged}, 0);
    step("postreset", 1'b1, 1'b0, 1'b0, 3, 0, 100);
    step("postreset", 1'b1, 1'b0, 1'b1, 3, 0, 100);
    frames("postreset", 17, 3, 0, 100);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
